// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath widths, register indices and common types.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/wb_mux.sv
// Write-back result select: load data or ALU result, purely combinational.
module wb_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              memtoregW,
  input  logic [DATA_W-1:0] aluoutW,
  input  logic [DATA_W-1:0] readdataW,
  output logic [DATA_W-1:0] resultW
);

  // Pick the write-back source for this instruction.
  always_comb begin
    resultW = {DATA_W{1'b0}};
    if (memtoregW) begin
      resultW = readdataW;
    end else begin
      resultW = aluoutW;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 2-read/1-write GPR file with a retired-write counter.
// Define WB_REGFILE_BYPASS_EN to forward the WB result to same-cycle decode reads.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwW,
  input  logic              memtoregW,
  input  logic [DATA_W-1:0] aluoutW,
  input  logic [DATA_W-1:0] readdataW,
  input  logic [ADDR_W-1:0] writeregW,
  input  logic [ADDR_W-1:0] ra1D,
  input  logic [ADDR_W-1:0] ra2D,
  output logic [DATA_W-1:0] rd1D,
  output logic [DATA_W-1:0] rd2D,
  output logic [DATA_W-1:0] resultW,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] gpr_r [0:REGS-1];
  logic [CNT_W-1:0]  wrCnt_r;
  logic              writeEn_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;

  wb_mux #(
    .DATA_W(DATA_W)
  ) u_wb_mux (
    .memtoregW(memtoregW),
    .aluoutW  (aluoutW),
    .readdataW(readdataW),
    .resultW  (resultW)
  );

  // Writes to $0 are dropped entirely, including the counter bump.
  assign writeEn_s = regwW && (writeregW != ZERO_REG);

  // Register array and counter: async clear, commit on enabled write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        gpr_r[i] <= {DATA_W{1'b0}};
      end
      wrCnt_r <= {CNT_W{1'b0}};
    end else if (writeEn_s) begin
      gpr_r[writeregW] <= resultW;
      wrCnt_r          <= wrCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Read port 1: $0 and reset force zero; optional write-through on index match.
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    if (!rst_n || (ra1D == ZERO_REG)) begin
      rd1_s = {DATA_W{1'b0}};
`ifdef WB_REGFILE_BYPASS_EN
    end else if (writeEn_s && (ra1D == writeregW)) begin
      rd1_s = resultW;
`endif
    end else begin
      rd1_s = gpr_r[ra1D];
    end
  end

  // Read port 2: resolved independently of port 1.
  always_comb begin
    rd2_s = {DATA_W{1'b0}};
    if (!rst_n || (ra2D == ZERO_REG)) begin
      rd2_s = {DATA_W{1'b0}};
`ifdef WB_REGFILE_BYPASS_EN
    end else if (writeEn_s && (ra2D == writeregW)) begin
      rd2_s = resultW;
`endif
    end else begin
      rd2_s = gpr_r[ra2D];
    end
  end

  assign rd1D   = rd1_s;
  assign rd2D   = rd2_s;
  assign wr_cnt = wrCnt_r;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus general-purpose register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB outputs: regwW, memtoregW, the ALU result, the load data and the destination register number.
- Selects the write-back value, commits it to 32x32 GPRs, and serves the two decode-stage read ports.
- Sits directly downstream of the MEM/WB control register and feeds the ID stage and the forwarding network.

Parameters:
- DATA_W, 32, register and datapath width.
- ADDR_W, 5, register index width; register count = 2**ADDR_W.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- regwW  in  1  write-back enable from MEM/WB.
- memtoregW  in  1  1 = write load data, 0 = write ALU result.
- aluoutW  in  DATA_W  ALU result in WB.
- readdataW  in  DATA_W  load data in WB.
- writeregW  in  ADDR_W  destination register index.
- ra1D  in  ADDR_W  read port 1 index (rs).
- ra2D  in  ADDR_W  read port 2 index (rt).
- rd1D  out  DATA_W  read port 1 data.
- rd2D  out  DATA_W  read port 2 data.
- resultW  out  DATA_W  selected write-back value, for forwarding to EX.
- wr_cnt  out  CNT_W  count of committed non-zero-register writes.

Behaviour:
- Reset: asynchronous, active-low.
  - On rst_n low, all 32 registers clear to 0 immediately and wr_cnt clears to 0.
  - Both rd1D and rd2D read 0 while in reset.
  - resultW stays combinational and is unaffected by reset.
- Write-back mux: resultW = memtoregW ? readdataW : aluoutW. Purely combinational, zero latency.
- Write:
  - On posedge clk with rst_n high, regwW=1 and writeregW!=0: GPR[writeregW] <= resultW.
  - The value is visible to array reads from the next cycle.
- Register 0:
  - Never written; always reads 0.
  - A write with writeregW=0 is silently dropped and does not increment wr_cnt.
- Read: combinational array reads: rdN = (raN==0) ? 0 : GPR[raN]. Same-cycle bypass is governed by the Optional Feature.
- Counter:
  - wr_cnt increments by 1 on every committed write.
  - Wraps from 2**CNT_W-1 to 0 with no saturation and no flag.
- Simultaneous events:
  - Both read ports may address the same register, or the register being written, in the same cycle.
  - Each port resolves independently.
- Reset mid-operation: a write pending in the same cycle that rst_n asserts is lost; the registers stay 0.
- Control contract: regwW and memtoregW arrive already registered from MEM/WB. No internal pipeline state beyond the register array and the counter.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined:
  - Internal write-through: if regwW=1, writeregW!=0 and raN==writeregW, then rdN = resultW in the same cycle.
  - The decode stage therefore sees a WB-stage result without a stall.
- Undefined:
  - Reads return the array contents only; the pre-edge value is returned on a same-cycle match.
  - The hazard unit must stall or forward for the WB->ID distance.
- Register-0 rule holds in both builds.

Decomposition:
- Shared package (mips_pkg):
  - DATA_W, ADDR_W, REG_NUM=32, ZERO_REG=0.
  - Typedef reg_idx_t (ADDR_W bits) and word_t (DATA_W bits).
- One natural sub-module: wb_mux (result select), instantiated once.
- The register array and counter remain in wb_regfile.

Test Plan:
- Reset: hold rst_n=0 mid-run after writes to $5 -> rd1D for ra1D=5 reads 0 immediately, without waiting for a clock edge; wr_cnt=0.
- ALU write: regwW=1, memtoregW=0, aluoutW=32'h1234_5678, writeregW=8; next cycle ra1D=8 -> rd1D=32'h1234_5678, wr_cnt=1.
- Load write: memtoregW=1, readdataW=32'hDEAD_BEEF, aluoutW=32'h0, writeregW=31 -> resultW=32'hDEAD_BEEF, and $31 holds it after the edge.
- Zero register: regwW=1, writeregW=0, aluoutW=32'hFFFF_FFFF -> rd1D for ra1D=0 stays 0 and wr_cnt is unchanged.
- Same-cycle read of $3 (old value 32'h11) while writing $3 with 32'h22:
  - With WB_REGFILE_BYPASS_EN, both ports read 32'h22.
  - Without it, both read 32'h11, then 32'h22 the next cycle.
- Counter wrap: force wr_cnt to 32'hFFFF_FFFF, commit one write -> wr_cnt=0.
